// File: rtl/hwpe_ctrl_uloop_sequencer_pkg.sv
// Shared HWPE controller types: microcode processor control/flags structs and
// the micro-loop sequencer state encoding and default sizes.
package hwpe_ctrl_package;

  localparam int unsigned UCODE_NB_LOOPS  = 6;
  localparam int unsigned UCODE_NB_REG    = 4;
  localparam int unsigned UCODE_REG_WIDTH = 32;
  localparam int unsigned UCODE_CNT_WIDTH = 12;

  localparam int unsigned ULOOP_SEQ_NB_STREAMS = 4;
  localparam int unsigned ULOOP_SEQ_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                              enable;
    logic                              clear;
    logic [$clog2(UCODE_NB_LOOPS)-1:0] accum_loop;
  } ctrl_ucode_t;

  typedef struct packed {
    logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] idx;
    logic [UCODE_NB_REG-1:0][UCODE_REG_WIDTH-1:0]   offs;
    logic                                           done;
    logic                                           valid;
    logic                                           accum;
  } flags_ucode_t;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_CLEAR   = 3'd1,
    SEQ_ISSUE   = 3'd2,
    SEQ_COMPUTE = 3'd3,
    SEQ_UPDATE  = 3'd4,
    SEQ_FINISH  = 3'd5
  } uloop_seq_state_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_sequencer_if.sv
// Stream job request bus between the micro-loop sequencer and the streamers.
interface hwpe_ctrl_uloop_sequencer_if
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_STREAMS = ULOOP_SEQ_NB_STREAMS,
  parameter int unsigned ADDR_WIDTH = 32
);
  // A job transfers on a cycle with req_valid & req_ready. Once raised,
  // req_valid, req_addr and req_accum hold until that cycle; valid never
  // depends on ready. Only a soft clear may withdraw a pending request.
  logic                                 req_valid;
  logic                                 req_ready;
  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic                                 req_accum;

  modport master (output req_valid, output req_addr, output req_accum, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_accum, output req_ready);

endinterface

// File: rtl/hwpe_ctrl_uloop_sequencer_addrgen.sv
// Per-stream job address generator: base plus selected microcode offset,
// captured once when a job is about to be issued and held until the next one.
module hwpe_ctrl_uloop_addrgen
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_STREAMS = ULOOP_SEQ_NB_STREAMS,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NB_REG     = UCODE_NB_REG,
  parameter int unsigned REG_WIDTH  = UCODE_REG_WIDTH
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         capture_i,
  input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [NB_STREAMS-1:0][$clog2(NB_REG)-1:0]    offs_sel_i,
  input  logic [UCODE_NB_REG-1:0][UCODE_REG_WIDTH-1:0] offs_i,
  input  logic                                         accum_i,
  output logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]        addr_o,
  output logic                                         accum_o
);

  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                                  accum_d, accum_q;

  // Offsets are unsigned: zero-extend and let the sum wrap at ADDR_WIDTH.
  always_comb begin
    addr_d  = addr_q;
    accum_d = accum_q;
    if (capture_i) begin
      for (int unsigned s = 0; s < NB_STREAMS; s++) begin
        addr_d[s] = base_addr_i[s] + ADDR_WIDTH'(offs_i[offs_sel_i[s]][REG_WIDTH-1:0]);
      end
      accum_d = accum_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      accum_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      accum_q <= accum_d;
    end
  end

  assign addr_o  = addr_q;
  assign accum_o = accum_q;

endmodule

// File: rtl/hwpe_ctrl_uloop_sequencer.sv
// Micro-loop sequencer: issues one stream job per microcode iteration, waits for
// all streamers, then steps the microcode processor until the loop nest ends.
module hwpe_ctrl_uloop_sequencer
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_STREAMS = ULOOP_SEQ_NB_STREAMS,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NB_REG     = UCODE_NB_REG,
  parameter int unsigned REG_WIDTH  = UCODE_REG_WIDTH,
  parameter int unsigned CNT_WIDTH  = ULOOP_SEQ_CNT_WIDTH
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      test_mode_i,
  input  logic                                      clear_i,
  input  logic                                      start_i,
  input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [NB_STREAMS-1:0][$clog2(NB_REG)-1:0] offs_sel_i,
  input  logic [$clog2(UCODE_NB_LOOPS)-1:0]         accum_loop_i,
  output ctrl_ucode_t                               ucode_ctrl_o,
  input  flags_ucode_t                              ucode_flags_i,
  hwpe_ctrl_uloop_sequencer_if.master               req,
  input  logic [NB_STREAMS-1:0]                     stream_done_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic [CNT_WIDTH-1:0]                      job_cnt_o,
  output uloop_seq_state_t                          state_o
);

  uloop_seq_state_t      state_d, state_q;
  logic [NB_STREAMS-1:0] sticky_d, sticky_q;
  logic [CNT_WIDTH-1:0]  job_cnt_d, job_cnt_q;
  logic                  req_valid_d, req_valid_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  handshake, all_done, capture;
  logic                  unused_inputs;

  assign handshake = req_valid_q & req.req_ready;
  // The current cycle's pulses count too, so simultaneous last pulses exit at once.
  assign all_done  = &(sticky_q | stream_done_i);
  assign capture   = (state_d == SEQ_ISSUE) && (state_q != SEQ_ISSUE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEQ_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE:    if (start_i) state_d = SEQ_CLEAR;
      SEQ_CLEAR:   state_d = SEQ_ISSUE;
      SEQ_ISSUE:   if (handshake) state_d = SEQ_COMPUTE;
      SEQ_COMPUTE: if (all_done) state_d = SEQ_UPDATE;
      SEQ_UPDATE:  if (ucode_flags_i.valid) state_d = ucode_flags_i.done ? SEQ_FINISH : SEQ_ISSUE;
      SEQ_FINISH:  state_d = SEQ_IDLE;
      default:     state_d = SEQ_IDLE;
    endcase
    if (clear_i) state_d = SEQ_IDLE;
  end

  always_comb begin
    ucode_ctrl_o            = '0;
    ucode_ctrl_o.enable     = (state_q == SEQ_UPDATE);
    ucode_ctrl_o.clear      = (state_q == SEQ_CLEAR) || clear_i;
    ucode_ctrl_o.accum_loop = accum_loop_i;
  end

  always_comb begin
    sticky_d  = sticky_q;
    job_cnt_d = job_cnt_q;
    if (clear_i) begin
      sticky_d  = '0;
      job_cnt_d = '0;
    end else begin
      if ((state_q == SEQ_IDLE) && start_i) job_cnt_d = '0;
      if ((state_q == SEQ_ISSUE) && handshake) begin
        sticky_d  = '0;
        job_cnt_d = job_cnt_q + CNT_WIDTH'(1);
      end
      if (state_q == SEQ_COMPUTE) sticky_d = sticky_q | stream_done_i;
    end
    req_valid_d = (state_d == SEQ_ISSUE);
    busy_d      = (state_d != SEQ_IDLE);
    done_d      = (state_d == SEQ_FINISH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q    <= '0;
      job_cnt_q   <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sticky_q    <= sticky_d;
      job_cnt_q   <= job_cnt_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  hwpe_ctrl_uloop_addrgen #(
    .NB_STREAMS (NB_STREAMS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB_REG     (NB_REG),
    .REG_WIDTH  (REG_WIDTH)
  ) i_addrgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .capture_i   (capture),
    .base_addr_i (base_addr_i),
    .offs_sel_i  (offs_sel_i),
    .offs_i      (ucode_flags_i.offs),
    .accum_i     (ucode_flags_i.accum),
    .addr_o      (req.req_addr),
    .accum_o     (req.req_accum)
  );

  assign req.req_valid = req_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign job_cnt_o     = job_cnt_q;
  assign state_o       = state_q;

  assign unused_inputs = ^{test_mode_i, ucode_flags_i.idx};

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sequencer.sv
// Bench for the micro-loop sequencer: microcode and streamer models, a job
// scoreboard and directed scenarios with randomized configurations.
module tb_hwpe_ctrl_uloop_sequencer;
  import hwpe_ctrl_package::*;

  localparam int NS   = 4;
  localparam int AW   = 32;
  localparam int CW   = 16;
  localparam int NR   = UCODE_NB_REG;
  localparam int SW   = $clog2(NR);
  localparam int MAXJ = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   test_mode = 1'b0, clear = 1'b0, start = 1'b0, stray_start = 1'b0;
  logic                   start_in;
  logic [NS-1:0][AW-1:0]  base;
  logic [NS-1:0][SW-1:0]  sel;
  logic [2:0]             accum_loop;
  ctrl_ucode_t            ctrl;
  flags_ucode_t           flags;
  logic [NS-1:0]          sdone;
  logic                   busy, done;
  logic [CW-1:0]          job_cnt;
  uloop_seq_state_t       dbg_state;

  assign start_in = start | stray_start;

  hwpe_ctrl_uloop_sequencer_if #(.NB_STREAMS(NS), .ADDR_WIDTH(AW)) req_if ();

  hwpe_ctrl_uloop_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_mode_i   (test_mode),
    .clear_i       (clear),
    .start_i       (start_in),
    .base_addr_i   (base),
    .offs_sel_i    (sel),
    .accum_loop_i  (accum_loop),
    .ucode_ctrl_o  (ctrl),
    .ucode_flags_i (flags),
    .req           (req_if),
    .stream_done_i (sdone),
    .busy_o        (busy),
    .done_o        (done),
    .job_cnt_o     (job_cnt),
    .state_o       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic          exp_acc_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- environment model state ----------------
  logic [UCODE_REG_WIDTH-1:0] offs_tab[MAXJ+1][NR];
  logic acc_tab[MAXJ+1];
  int  n_iter = 1, u_lat = 0, u_it = 0, u_wait = 0;
  int  cyc = 0, upd_start = 0, exp_done_cyc = -1;
  int  done_at[NS];
  int  d_fix[NS];
  bit  upd_pending = 0, fixed_d = 0, stray_en = 0, prev_v_chk = 0;
  int  hold_low = 0, ready_pct = 100;
  logic [NS-1:0][AW-1:0] prev_a;
  logic prev_acc;

  // Monitor and reference bookkeeping, sampled mid-cycle.
  initial begin
    logic v, r, hs, ac, en, fv, fd, dn, cl, exp_en;
    logic [NS-1:0][AW-1:0] a;
    int d, mx;
    for (int s = 0; s < NS; s++) done_at[s] = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_it = 0; u_wait = 0; upd_pending = 0; exp_done_cyc = -1; prev_v_chk = 0;
        for (int s = 0; s < NS; s++) done_at[s] = -1;
        continue;
      end
      v = req_if.req_valid; r = req_if.req_ready; a = req_if.req_addr; ac = req_if.req_accum;
      en = ctrl.enable; cl = ctrl.clear; fv = flags.valid; fd = flags.done; dn = done;
      hs = v && r;
      if (prev_v_chk) begin
        check("hold_valid", v, 1'b1);
        check("hold_addr", a, prev_a);
        check("hold_accum", ac, prev_acc);
      end
      if (hs) begin
        if (exp_q.size() >= NS) begin
          for (int s = 0; s < NS; s++) check($sformatf("job_addr%0d", s), a[s], exp_q.pop_front());
          check("job_accum", ac, exp_acc_q.pop_front());
        end else begin
          check("job_unexpected", exp_q.size(), NS);
        end
      end
      prev_v_chk = v && !hs && !cl;
      prev_a = a; prev_acc = ac;
      exp_en = upd_pending && (cyc >= upd_start);
      check("ucode_enable", en, exp_en);
      check("done_pulse", dn, cyc == exp_done_cyc);
      if (cl) begin
        u_it = 0; u_wait = 0; upd_pending = 0; exp_done_cyc = -1;
        for (int s = 0; s < NS; s++) done_at[s] = -1;
      end else begin
        if (hs) begin
          mx = 0;
          for (int s = 0; s < NS; s++) begin
            d = fixed_d ? d_fix[s] : $urandom_range(1, 8);
            done_at[s] = cyc + d;
            if (d > mx) mx = d;
          end
          upd_start = cyc + mx + 1;
          upd_pending = 1;
        end
        if (en && fv) begin
          upd_pending = 0; u_wait = 0;
          if (fd) begin exp_done_cyc = cyc + 1; u_it = 0; end
          else u_it++;
        end else if (en) begin
          u_wait++;
        end
      end
    end
  end

  // Microcode, streamer and ready drivers, updated just after each edge.
  initial begin
    logic [NS-1:0] nd;
    int idx;
    sdone = '0; flags = '0; req_if.req_ready = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int s = 0; s < NS; s++) nd[s] = (done_at[s] == cyc);
      if (stray_en && req_if.req_valid && ($urandom_range(0, 2) == 0)) nd[$urandom_range(0, NS-1)] = 1'b1;
      sdone = nd;
      stray_start = stray_en && ctrl.enable;
      if (hold_low > 0 && req_if.req_valid) begin
        req_if.req_ready = 1'b0;
        hold_low--;
      end else begin
        req_if.req_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      idx = u_it + (ctrl.enable ? 1 : 0);
      if (idx > MAXJ) idx = MAXJ;
      flags = '0;
      for (int r = 0; r < NR; r++) flags.offs[r] = offs_tab[idx][r];
      flags.accum = acc_tab[idx];
      flags.valid = ctrl.enable && (u_wait >= u_lat);
      flags.done  = ctrl.enable && (u_it + 1 >= n_iter);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal;
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_cfg();
    for (int s = 0; s < NS; s++) begin
      base[s] = $urandom();
      sel[s]  = SW'($urandom_range(0, NR-1));
    end
    for (int k = 0; k <= MAXJ; k++) begin
      for (int r = 0; r < NR; r++) offs_tab[k][r] = $urandom();
      acc_tab[k] = 1'($urandom_range(0, 1));
    end
    u_lat = $urandom_range(0, 3);
    ready_pct = $urandom_range(30, 100);
    accum_loop = 3'($urandom_range(0, 5));
  endtask

  task automatic push_jobs(input int n);
    logic [AW-1:0] ea;
    n_iter = n;
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < NS; s++) begin
        ea = base[s] + offs_tab[k][sel[s]];
        exp_q.push_back(ea);
      end
      exp_acc_q.push_back(acc_tab[k]);
    end
  endtask

  task automatic run_nest(input string tag, input int n);
    bit got;
    got = 0;
    push_jobs(n);
    @(posedge clk); #1; start = 1'b1;
    @(negedge clk); check({tag, "_busy_t0"}, busy, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_t1"}, busy, 1'b1);
    check({tag, "_uclear_t1"}, ctrl.clear, 1'b1);
    check({tag, "_valid_t1"}, req_if.req_valid, 1'b0);
    @(negedge clk); check({tag, "_valid_t2"}, req_if.req_valid, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    check({tag, "_finished"}, got, 1'b1);
    check({tag, "_job_cnt"}, job_cnt, n);
    check({tag, "_jobs_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_done_width"}, done, 1'b0);
    exp_q.delete(); exp_acc_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, req_if.req_valid, 1'b0);
    check({tag, "_addr"}, req_if.req_addr, '0);
    check({tag, "_accum"}, req_if.req_accum, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_job_cnt"}, job_cnt, 0);
    check({tag, "_enable"}, ctrl.enable, 1'b0);
    check({tag, "_uclear"}, ctrl.clear, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;
    base = '0; sel = '0; accum_loop = 3'd2;
    for (int k = 0; k <= MAXJ; k++) begin
      for (int r = 0; r < NR; r++) offs_tab[k][r] = '0;
      acc_tab[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); check("accum_loop_fwd", ctrl.accum_loop, accum_loop);

    // single iteration
    randomize_cfg();
    base[0] = 32'h0000_1000; sel[0] = '0; offs_tab[0][0] = 32'h40; acc_tab[0] = 1'b1;
    u_lat = 0; ready_pct = 100;
    run_nest("single", 1);

    // three iterations stepping the offsets
    randomize_cfg();
    for (int k = 0; k < 3; k++) for (int r = 0; r < NR; r++) offs_tab[k][r] = 32'(k * 16);
    run_nest("three", 3);

    // backpressure on the first job
    randomize_cfg();
    ready_pct = 100; hold_low = 5;
    run_nest("bp", 1);

    // staggered completion with stray pulses and ignored starts
    randomize_cfg();
    fixed_d = 1; d_fix = '{3, 7, 7, 12}; stray_en = 1;
    run_nest("stagger", 2);
    fixed_d = 0; stray_en = 0;

    // address wrap
    randomize_cfg();
    for (int s = 0; s < NS; s++) base[s] = 32'hFFFF_FFF0;
    for (int r = 0; r < NR; r++) offs_tab[0][r] = 32'h20;
    run_nest("wrap", 1);

    // randomized nests
    for (int run = 0; run < 6; run++) begin
      randomize_cfg();
      stray_en = ($urandom_range(0, 1) == 1);
      run_nest($sformatf("rand%0d", run), $urandom_range(1, 5));
    end
    stray_en = 0;

    // soft clear while computing
    randomize_cfg();
    fixed_d = 1; d_fix = '{10, 10, 10, 10}; ready_pct = 100;
    push_jobs(2);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_if.req_valid && req_if.req_ready) begin got = 1; break; end
    end
    check("clr_handshake", got, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1; clear = 1'b1;
    @(negedge clk);
    check("clr_uclear", ctrl.clear, 1'b1);
    check("clr_busy_before", busy, 1'b1);
    check("clr_cnt_before", job_cnt, 1);
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 1'b0);
    check("clr_job_cnt", job_cnt, 0);
    check("clr_valid", req_if.req_valid, 1'b0);
    exp_q.delete(); exp_acc_q.delete(); fixed_d = 0;
    repeat (3) @(negedge clk);

    // asynchronous reset while a request is pending
    randomize_cfg();
    ready_pct = 0;
    push_jobs(1);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_pending_valid", req_if.req_valid, 1'b1);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check_reset_values("rst_async");
    exp_q.delete(); exp_acc_q.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; ready_pct = 100;
    repeat (2) @(negedge clk);

    // recovery after reset
    randomize_cfg();
    run_nest("recover", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_uloop_sequencer.md
# hwpe_ctrl_uloop_sequencer

Control-side sequencer that sits directly downstream of the HWPE microcode loop processor (`hwpe_ctrl_ucode`).
- Per iteration, it issues one stream job whose per-stream addresses are `base + ucode offset`.
- It waits for every streamer to report completion.
- It then clocks the microcode processor until the processor publishes the next offset set.
- It repeats until the processor signals the end of the loop nest.

It is instantiated inside the HWPE controller, between the register file and the streamers.

## Interface
Parameters:
- `NB_STREAMS`, default 4: number of streamers addressed per job.
- `ADDR_WIDTH`, default 32: stream address width.
- `NB_REG`, default `UCODE_NB_REG`: number of microcode offset registers.
- `REG_WIDTH`, default `UCODE_REG_WIDTH`: offset register width. Must be ≤ `ADDR_WIDTH`.
- `CNT_WIDTH`, default 16: job counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `test_mode_i`  in  1  unused; kept for interface uniformity.
- `clear_i`  in  1  synchronous soft clear.
- `start_i`  in  1  start pulse; honoured only in IDLE.
- `base_addr_i`  in  `NB_STREAMS`×`ADDR_WIDTH`  per-stream base address; static while busy.
- `offs_sel_i`  in  `NB_STREAMS`×`$clog2(NB_REG)`  offset register index per stream; static while busy.
- `accum_loop_i`  in  `$clog2(UCODE_NB_LOOPS)`  forwarded to `ucode_ctrl_o.accum_loop`.
- `ucode_ctrl_o`  out  `ctrl_ucode_t`  enable/clear/accum_loop to the microcode processor.
- `ucode_flags_i`  in  `flags_ucode_t`  offs/idx/done/valid/accum from the microcode processor.
- `req_valid_o`  out  1  job request valid.
- `req_ready_i`  in  1  job request ready.
- `req_addr_o`  out  `NB_STREAMS`×`ADDR_WIDTH`  job addresses.
- `req_accum_o`  out  1  accumulate flag for this job.
- `stream_done_i`  in  `NB_STREAMS`  per-stream completion pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle end-of-nest pulse.
- `job_cnt_o`  out  `CNT_WIDTH`  accepted jobs since the last start.

## Operation
States: IDLE, CLEAR, ISSUE, COMPUTE, UPDATE, FINISH.
- **IDLE:** on `start_i`, zero `job_cnt`, go to CLEAR.
- **CLEAR:** `ucode_ctrl_o.clear`=1 for exactly one cycle, then go to ISSUE.
- **ISSUE:**
  - `req_valid_o`=1.
  - `req_addr_o[s] = base_addr_i[s] + zero-extended ucode_flags_i.offs[offs_sel_i[s]]`, computed modulo 2^`ADDR_WIDTH` (wrap, no saturation).
  - `req_accum_o = ucode_flags_i.accum`.
  - Address and accum values are registered on entry to ISSUE and held stable until the handshake.
  - On the cycle `req_valid_o` & `req_ready_i` are both high: `job_cnt`+1 (wraps), clear the sticky done vector, go to COMPUTE.
- **COMPUTE:**
  - Sticky done vector `|=` `stream_done_i`.
  - When `(sticky | stream_done_i)` is all-ones, go to UPDATE.
  - `stream_done_i` pulses outside COMPUTE are ignored.
- **UPDATE:**
  - `ucode_ctrl_o.enable`=1 every cycle.
  - On the first cycle with `ucode_flags_i.valid`=1: if `ucode_flags_i.done`=1, go to FINISH; otherwise go to ISSUE.
- **FINISH:** `done_o`=1 for one cycle, then go to IDLE.
- **`clear_i`:**
  - Highest priority, in any state.
  - Next state is IDLE; sticky vector and `job_cnt` are zeroed.
  - `ucode_ctrl_o.clear`=1 combinationally in that cycle.
  - An in-flight `req_valid_o` is dropped; this is the only permitted case of valid withdrawal.
- **`start_i` outside IDLE:** ignored.
- **`test_mode_i`:** no effect.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_valid_o`=0, `req_addr_o`=0, `req_accum_o`=0.
  - `busy_o`=0, `done_o`=0, `job_cnt_o`=0.
  - `ucode_ctrl_o.enable`=0, `ucode_ctrl_o.clear`=0.
- **Start latency:**
  - `start_i` at cycle t: CLEAR at t+1.
  - `req_valid_o` high at t+2.
  - `busy_o` high from t+1.
- **Handshake:** AXI-stream style. Valid never depends combinationally on ready. If ready is high in the first ISSUE cycle, the handshake completes in that cycle and COMPUTE is entered next cycle.
- **COMPUTE exit:** all streams done (last pulse at cycle c) gives UPDATE at c+1. Simultaneous last pulses are accepted in the same cycle.
- **UPDATE exit:** `ucode_flags_i.valid` at cycle u gives ISSUE or FINISH at u+1. Enable drops at u+1.
- **`done_o`:** registered, one cycle. `busy_o` deasserts in the cycle after FINISH.
- **Outputs:** all registered except `ucode_ctrl_o.clear` and `ucode_ctrl_o.enable`, which are decoded from state (and from `clear_i` for clear).

## Structure
- Add to `hwpe_ctrl_package`:
  - `uloop_seq_state_t` enum.
  - Default `NB_STREAMS`/`CNT_WIDTH` constants.
- Reuse the existing `ctrl_ucode_t` and `flags_ucode_t`.
- One sub-module is natural: `hwpe_ctrl_uloop_addrgen`, the per-stream offset-select, add, and capture register.
- The FSM, sticky done vector and counter stay in the top module.

## Test plan
- **Single iteration:** reset, `start_i`, ucode model returns `valid=1, done=1` on first UPDATE, `offs[0]`=0x40, base 0x1000 → one job at 0x1040, `done_o` pulse, `job_cnt_o`=1.
- **Three iterations:** ucode model steps offs 0, 0x10, 0x20 → addresses base+0, +0x10, +0x20; `job_cnt_o`=3; enable only in UPDATE.
- **Backpressure:** `req_ready_i` low for 5 cycles → valid and addresses held constant; count increments once.
- **Staggered done:** streams finish at cycles 3, 7, 7, 12 after handshake, plus a stray pulse in ISSUE → UPDATE entered exactly the cycle after 12; the stray pulse is ignored.
- **Wrap:** base 0xFFFF_FFF0 + offs 0x20 → address 0x0000_0010.
- **Clear mid-COMPUTE:** `clear_i` → IDLE next cycle, `ucode_ctrl_o.clear`=1 that cycle, `busy_o`=0, `job_cnt_o`=0; asserting `rst_ni`=0 mid-ISSUE yields all reset values immediately.
